// File: rtl/mult_unit.sv
// mult_unit: signed 32x32 shift-add multiplier committing to HI/LO with MFHI/MFLO read and PC stall
module mult_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_mult,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        mfhi_sel,
    input  logic        mflo_sel,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data,
    output logic        busy,
    output logic        done,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t      r_state, w_next;
    logic [63:0] r_acc, r_mcand, w_prod;
    logic [31:0] r_mplier, w_mag_a, w_mag_b;
    logic [5:0]  r_cnt;
    logic        r_neg, r_done;
    assign w_mag_a = srca[31] ? -srca : srca;
    assign w_mag_b = srcb[31] ? -srcb : srcb;
    assign w_prod  = r_neg ? -r_acc : r_acc;
    assign busy    = r_state != IDLE;
    assign done    = r_done;
    assign stall   = busy & (start_mult | mfhi_sel | mflo_sel);
    assign mf_data = mfhi_sel ? hi : mflo_sel ? lo : 32'd0;
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (start_mult ? RUN : IDLE) :
                 (r_state == RUN)  ? ((r_cnt == 6'd31) ? FIX : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            r_acc  <= 64'd0;
            r_cnt  <= 6'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= r_state == FIX;
            if (r_state == IDLE && start_mult) begin
                r_mcand  <= {32'd0, w_mag_a};
                r_mplier <= w_mag_b;
                r_neg    <= srca[31] ^ srcb[31];
                r_acc    <= 64'd0;
                r_cnt    <= 6'd0;
            end else if (r_state == RUN) begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 6'd1;
            end else if (r_state == FIX) begin
                {hi, lo} <= w_prod;
            end
        end
    end
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed-vector self-checking bench for mult_unit
module tb_mult_unit;
    logic        clk = 1'b0, reset_n = 1'b0, start_mult = 1'b0, mfhi_sel = 1'b0, mflo_sel = 1'b0;
    logic [31:0] srca = 32'd0, srcb = 32'd0;
    logic [31:0] hi, lo, mf_data;
    logic        busy, done, stall;
    int          checks = 0, failures = 0;
    always #5 clk = ~clk;
    mult_unit dut (
        .clk(clk), .reset_n(reset_n), .start_mult(start_mult), .srca(srca), .srcb(srcb),
        .mfhi_sel(mfhi_sel), .mflo_sel(mflo_sel), .hi(hi), .lo(lo), .mf_data(mf_data),
        .busy(busy), .done(done), .stall(stall)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic wait_done(output int edges, output int bcyc);
        edges = 0;
        bcyc  = 0;
        while (!done && edges < 40) begin
            if (busy) bcyc++;
            step();
            edges++;
        end
    endtask
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input string tag);
        int e, bc;
        srca = a;
        srcb = b;
        start_mult = 1'b1;
        step();
        start_mult = 1'b0;
        wait_done(e, bc);
        chk({tag, "_lat"}, e, 33);
        chk({tag, "_busy"}, bc, 33);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_done"}, done, 1);
        step();
        chk({tag, "_done_off"}, done, 0);
    endtask
    initial begin
        int e, bc, pulses;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_stall", stall, 0);
        reset_n = 1'b1;
        run(32'd3, 32'd5, 32'h0, 32'hF, "p3x5");
        run(32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, "n2x3");
        run(32'h80000000, 32'h80000000, 32'h40000000, 32'h0, "min_sq");
        run(32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, "max_min");
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, "m1xm1");
        run(32'h00010000, 32'h00010000, 32'h1, 32'h0, "p16xp16");
        run(32'h0, 32'h12345, 32'h0, 32'h0, "zero");
        run(32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB, "m1x5");
        mfhi_sel = 1'b1;
        mflo_sel = 1'b1;
        #1 chk("idle_mf_pri", mf_data, 32'hFFFFFFFF);
        chk("idle_stall", stall, 0);
        mfhi_sel = 1'b0;
        #1 chk("idle_mflo", mf_data, 32'hFFFFFFFB);
        mflo_sel = 1'b0;
        #1 chk("idle_mf_none", mf_data, 0);
        srca = 32'd7;
        srcb = 32'd6;
        start_mult = 1'b1;
        step();
        start_mult = 1'b0;
        repeat (9) step();
        mflo_sel = 1'b1;
        #1 chk("mid_stall", stall, 1);
        chk("mid_mflo_old", mf_data, 32'hFFFFFFFB);
        chk("mid_hi_hold", hi, 32'hFFFFFFFF);
        mfhi_sel = 1'b1;
        #1 chk("mid_mfhi_old", mf_data, 32'hFFFFFFFF);
        mfhi_sel = 1'b0;
        wait_done(e, bc);
        chk("mf_done", done, 1);
        chk("mf_stall_off", stall, 0);
        chk("mf_new_lo", mf_data, 32'd42);
        mflo_sel = 1'b0;
        step();
        srca = 32'd9;
        srcb = 32'd9;
        start_mult = 1'b1;
        step();
        start_mult = 1'b0;
        repeat (9) step();
        reset_n = 1'b0;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            step();
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        chk("abort_lo_stay", lo, 0);
        reset_n = 1'b0;
        start_mult = 1'b1;
        srca = 32'd2;
        srcb = 32'd2;
        step();
        chk("rst_pri_busy", busy, 0);
        reset_n = 1'b1;
        start_mult = 1'b0;
        step();
        srca = 32'd3;
        srcb = 32'd4;
        start_mult = 1'b1;
        step();
        repeat (5) step();
        srca = 32'd5;
        srcb = 32'd6;
        #1 chk("busy_start_stall", stall, 1);
        wait_done(e, bc);
        chk("b2b_first_lat", e, 28);
        chk("b2b_first_hi", hi, 0);
        chk("b2b_first_lo", lo, 32'd12);
        step();
        start_mult = 1'b0;
        chk("b2b_second_busy", busy, 1);
        wait_done(e, bc);
        chk("b2b_second_lat", e, 33);
        chk("b2b_second_lo", lo, 32'd30);
        chk("b2b_second_hi", hi, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
